// File: rtl/ysyx_25060166_idu_stage.sv
// Registered RV32E/RV32I decode stage: decodes {pc, inst} at push time and
// holds decoded bundles in a DEPTH-entry queue toward the EXU.
module ysyx_25060166_idu_stage #(
  parameter int WIDTH   = 32,
  parameter int NR_REGS = 16,
  parameter int DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [WIDTH-1:0] out_imm,
  output logic [5:0]       out_alu_op,
  output logic             out_reg_wen,
  output logic             out_mem_ren,
  output logic             out_mem_wen,
  output logic             out_uncon_jump,
  output logic             out_illegal,
  output logic             out_ebreak,
  output logic             out_ecall
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // alu_op encoding, one code per supported instruction
  localparam logic [5:0] ALU_DEFAULT = 6'd0,
    ALU_ADDI = 6'd1,  ALU_SLTI = 6'd2,  ALU_SLTIU = 6'd3, ALU_XORI = 6'd4,
    ALU_ORI  = 6'd5,  ALU_ANDI = 6'd6,  ALU_SLLI  = 6'd7, ALU_SRLI = 6'd8,
    ALU_SRAI = 6'd9,  ALU_ADD  = 6'd10, ALU_SUB   = 6'd11, ALU_SLL = 6'd12,
    ALU_SLT  = 6'd13, ALU_SLTU = 6'd14, ALU_XOR   = 6'd15, ALU_SRL = 6'd16,
    ALU_SRA  = 6'd17, ALU_OR   = 6'd18, ALU_AND   = 6'd19, ALU_LB  = 6'd20,
    ALU_LH   = 6'd21, ALU_LW   = 6'd22, ALU_LBU   = 6'd23, ALU_LHU = 6'd24,
    ALU_SB   = 6'd25, ALU_SH   = 6'd26, ALU_SW    = 6'd27, ALU_BEQ = 6'd28,
    ALU_BNE  = 6'd29, ALU_BLT  = 6'd30, ALU_BGE   = 6'd31, ALU_BLTU = 6'd32,
    ALU_BGEU = 6'd33, ALU_JAL  = 6'd34, ALU_JALR  = 6'd35, ALU_LUI = 6'd36,
    ALU_AUIPC = 6'd37, ALU_EBREAK = 6'd38, ALU_ECALL = 6'd39;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1, rs2, rd;
    logic [WIDTH-1:0] imm;
    logic [5:0]       alu_op;
    logic             reg_wen, mem_ren, mem_wen, uncon_jump;
    logic             illegal, ebreak, ecall;
  } entry_t;

  entry_t          dec, head;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, legal, use_rs1, use_rs2, use_rd, reg_bad;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  assign imm_i = {{(WIDTH-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{(WIDTH-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{(WIDTH-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = WIDTH'({in_inst[31:12], 12'b0});
  assign imm_j = {{(WIDTH-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // in_ready depends on stored count only; rst masks both sides of the handshake
  assign in_ready  = ~rst & (count < CW'(DEPTH));
  assign out_valid = ~rst & (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // decode the incoming word into a queue entry, squashing illegal ones
  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    legal      = 1'b1;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    case (opc)
      7'b0010011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_i;
        case (f3)
          3'd0: dec.alu_op = ALU_ADDI;
          3'd2: dec.alu_op = ALU_SLTI;
          3'd3: dec.alu_op = ALU_SLTIU;
          3'd4: dec.alu_op = ALU_XORI;
          3'd6: dec.alu_op = ALU_ORI;
          3'd7: dec.alu_op = ALU_ANDI;
          3'd1: begin dec.alu_op = ALU_SLLI; legal = (f7 == 7'h00); end
          default: begin
            // funct7 includes imm[5], so shamt >= 32 falls out here
            if (f7 == 7'h00)      dec.alu_op = ALU_SRLI;
            else if (f7 == 7'h20) dec.alu_op = ALU_SRAI;
            else                  legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; dec.reg_wen = 1'b1;
        case ({f7, f3})
          10'h000: dec.alu_op = ALU_ADD;
          10'h001: dec.alu_op = ALU_SLL;
          10'h002: dec.alu_op = ALU_SLT;
          10'h003: dec.alu_op = ALU_SLTU;
          10'h004: dec.alu_op = ALU_XOR;
          10'h005: dec.alu_op = ALU_SRL;
          10'h006: dec.alu_op = ALU_OR;
          10'h007: dec.alu_op = ALU_AND;
          10'h100: dec.alu_op = ALU_SUB;
          10'h105: dec.alu_op = ALU_SRA;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; dec.reg_wen = 1'b1; dec.mem_ren = 1'b1; dec.imm = imm_i;
        case (f3)
          3'd0: dec.alu_op = ALU_LB;
          3'd1: dec.alu_op = ALU_LH;
          3'd2: dec.alu_op = ALU_LW;
          3'd4: dec.alu_op = ALU_LBU;
          3'd5: dec.alu_op = ALU_LHU;
          default: legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.mem_wen = 1'b1; dec.imm = imm_s;
        case (f3)
          3'd0: dec.alu_op = ALU_SB;
          3'd1: dec.alu_op = ALU_SH;
          3'd2: dec.alu_op = ALU_SW;
          default: legal = 1'b0;
        endcase
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_b;
        case (f3)
          3'd0: dec.alu_op = ALU_BEQ;
          3'd1: dec.alu_op = ALU_BNE;
          3'd4: dec.alu_op = ALU_BLT;
          3'd5: dec.alu_op = ALU_BGE;
          3'd6: dec.alu_op = ALU_BLTU;
          3'd7: dec.alu_op = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      7'b1101111: begin
        use_rd = 1'b1; dec.reg_wen = 1'b1; dec.uncon_jump = 1'b1; dec.imm = imm_j; dec.alu_op = ALU_JAL;
      end
      7'b1100111: begin
        use_rs1 = 1'b1; use_rd = 1'b1; dec.reg_wen = 1'b1; dec.uncon_jump = 1'b1;
        dec.imm = imm_i; dec.alu_op = ALU_JALR; legal = (f3 == 3'd0);
      end
      7'b0110111: begin use_rd = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_LUI; end
      7'b0010111: begin use_rd = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_AUIPC; end
      7'b1110011: begin
        if (in_inst == 32'h0010_0073)      begin dec.ebreak = 1'b1; dec.alu_op = ALU_EBREAK; end
        else if (in_inst == 32'h0000_0073) begin dec.ecall  = 1'b1; dec.alu_op = ALU_ECALL;  end
        else                                legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    reg_bad = (use_rs1 && int'(dec.rs1) >= NR_REGS) ||
              (use_rs2 && int'(dec.rs2) >= NR_REGS) ||
              (use_rd  && int'(dec.rd)  >= NR_REGS);
    if (!legal || reg_bad) begin
      dec.reg_wen    = 1'b0;
      dec.mem_ren    = 1'b0;
      dec.mem_wen    = 1'b0;
      dec.uncon_jump = 1'b0;
      dec.imm        = '0;
      dec.alu_op     = ALU_DEFAULT;
      dec.ebreak     = 1'b0;
      dec.ecall      = 1'b0;
      dec.illegal    = 1'b1;
    end
  end

  // output queue: flush empties it, push/pop move the ring pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head           = mem[rd_ptr];
  assign out_pc         = head.pc;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_rd         = head.rd;
  assign out_imm        = head.imm;
  assign out_alu_op     = head.alu_op;
  assign out_reg_wen    = head.reg_wen;
  assign out_mem_ren    = head.mem_ren;
  assign out_mem_wen    = head.mem_wen;
  assign out_uncon_jump = head.uncon_jump;
  assign out_illegal    = head.illegal;
  assign out_ebreak     = head.ebreak;
  assign out_ecall      = head.ecall;
endmodule
